// File: rtl/flipflop_bank_if.sv
// flipflop_bank_if: strobe/state bundle for flipflop_bank.
//   set, reset  : per-channel set/reset strobes (master -> slave)
//   clear_all   : synchronous bulk clear (master -> slave)
//   out         : registered flip-flop state (slave -> master)
//   out_bar     : bitwise inverse of out (slave -> master)
//   changed     : one-cycle per-channel change pulse (slave -> master)
//   count       : registered number of set channels (slave -> master)
interface flipflop_bank_if #(
  parameter int unsigned CHANNELS = 8
);
  localparam int unsigned CW = $clog2(CHANNELS + 1);

  logic [CHANNELS-1:0] set;
  logic [CHANNELS-1:0] reset;
  logic                clear_all;
  logic [CHANNELS-1:0] out;
  logic [CHANNELS-1:0] out_bar;
  logic [CHANNELS-1:0] changed;
  logic [CW-1:0]       count;

  modport master (
    output set, reset, clear_all,
    input  out, out_bar, changed, count
  );

  modport slave (
    input  set, reset, clear_all,
    output out, out_bar, changed, count
  );
endinterface

// File: rtl/flipflop_bank.sv
// flipflop_bank: bank of clocked set/reset control flip-flops for the EDSAC
// control logic (stop/run, order-decoder and sequencing flags).
//   clk  : single clock, all state updates on its rising edge
//   rst  : synchronous active-high reset; loads INIT and samples the
//          strobes into the edge history
//   bus  : flipflop_bank_if slave modport (set, reset, clear_all in;
//          out, out_bar, changed, count out)
// Parameters:
//   CHANNELS      : number of flip-flops (1..64)
//   CONFLICT_MODE : set&reset together -> 0 reset wins, 1 set wins,
//                   2 hold, 3 toggle
//   EDGE_DETECT   : 1 = act on rising edge of a strobe, 0 = level
//   INIT          : state loaded by rst
module flipflop_bank #(
  parameter int unsigned         CHANNELS      = 8,
  parameter int unsigned         CONFLICT_MODE = 1,
  parameter bit                  EDGE_DETECT   = 1'b1,
  parameter logic [CHANNELS-1:0] INIT          = '0
) (
  input  logic             clk,
  input  logic             rst,
  flipflop_bank_if.slave   bus
);
  localparam int unsigned CW = $clog2(CHANNELS + 1);

  typedef enum logic [1:0] {
    CM_RESET_WINS = 2'd0,
    CM_SET_WINS   = 2'd1,
    CM_HOLD       = 2'd2,
    CM_TOGGLE     = 2'd3
  } conflict_e;

  localparam logic [31:0] CM_BITS = CONFLICT_MODE;
  localparam conflict_e   CM      = conflict_e'(CM_BITS[1:0]);

  function automatic logic [CW-1:0] popcount(input logic [CHANNELS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  localparam logic [CW-1:0] INIT_COUNT = popcount(INIT);

  logic [CHANNELS-1:0] set_prev;
  logic [CHANNELS-1:0] reset_prev;
  logic [CHANNELS-1:0] s;
  logic [CHANNELS-1:0] r;
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] next_out;
  logic [CHANNELS-1:0] changed_q;
  logic [CW-1:0]       count_q;
  logic [CW-1:0]       next_count;

  always_comb begin
    if (EDGE_DETECT) begin
      s = bus.set   & ~set_prev;
      r = bus.reset & ~reset_prev;
    end else begin
      s = bus.set;
      r = bus.reset;
    end
  end

  always_comb begin
    next_out = out_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      case ({s[i], r[i]})
        2'b10:   next_out[i] = 1'b1;
        2'b01:   next_out[i] = 1'b0;
        2'b11: begin
          case (CM)
            CM_RESET_WINS: next_out[i] = 1'b0;
            CM_SET_WINS:   next_out[i] = 1'b1;
            CM_HOLD:       next_out[i] = out_q[i];
            CM_TOGGLE:     next_out[i] = ~out_q[i];
            default:       next_out[i] = out_q[i];
          endcase
        end
        default: next_out[i] = out_q[i];
      endcase
    end
    if (bus.clear_all) begin
      next_out = '0;
    end
    next_count = popcount(next_out);
  end

  // Edge history tracks the raw inputs every cycle, reset and clear_all
  // included, so a strobe held across either never shows up as a new edge.
  always_ff @(posedge clk) begin
    set_prev   <= bus.set;
    reset_prev <= bus.reset;
    if (rst) begin
      out_q     <= INIT;
      changed_q <= '0;
      count_q   <= INIT_COUNT;
    end else begin
      out_q     <= next_out;
      changed_q <= next_out ^ out_q;
      count_q   <= next_count;
    end
  end

  assign bus.out     = out_q;
  assign bus.out_bar = ~out_q;
  assign bus.changed = changed_q;
  assign bus.count   = count_q;
endmodule

// File: tb/tb_flipflop_bank.sv
// tb_flipflop_bank: directed stimulus with a cycle-stamped scoreboard.
// DUTs 0..3: 4 channels, INIT=1010, edge mode, conflict modes 0..3.
// DUT 4    : 4 channels, INIT=0, level mode, toggle conflict.
// DUT 5    : 64 channels, INIT=0, edge mode, set-wins conflict.
module tb_flipflop_bank;
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    int          dut;
    logic [63:0] out;
    logic [63:0] chg;
    logic [6:0]  cnt;
    string       name;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  logic [5:0][63:0] mon_out;
  logic [5:0][63:0] mon_bar;
  logic [5:0][63:0] mon_chg;
  logic [5:0][6:0]  mon_cnt;
  logic [63:0]      dmask [6];
  initial begin
    for (int i = 0; i < 5; i++) dmask[i] = 64'hF;
    dmask[5] = '1;
  end

  // Group A stimulus (shared by DUTs 0..3)
  logic       rst_a = 1'b1;
  logic [3:0] set_a = 4'b1111;
  logic [3:0] res_a = 4'b0000;
  logic       clr_a = 1'b0;
  // Group B (level)
  logic       rst_b = 1'b1;
  logic [3:0] set_b = '0;
  logic [3:0] res_b = '0;
  logic       clr_b = 1'b0;
  // Group C (wide)
  logic        rst_c = 1'b1;
  logic [63:0] set_c = '0;
  logic [63:0] res_c = '0;
  logic        clr_c = 1'b0;

  for (genvar m = 0; m < 4; m++) begin : g_mode
    flipflop_bank_if #(.CHANNELS(4)) bif ();
    assign bif.set       = set_a;
    assign bif.reset     = res_a;
    assign bif.clear_all = clr_a;
    flipflop_bank #(
      .CHANNELS(4), .CONFLICT_MODE(m), .EDGE_DETECT(1'b1), .INIT(4'b1010)
    ) dut (
      .clk(clk), .rst(rst_a), .bus(bif.slave)
    );
    assign mon_out[m] = 64'(bif.out);
    assign mon_bar[m] = 64'(bif.out_bar);
    assign mon_chg[m] = 64'(bif.changed);
    assign mon_cnt[m] = 7'(bif.count);
  end

  flipflop_bank_if #(.CHANNELS(4)) bif_l ();
  assign bif_l.set       = set_b;
  assign bif_l.reset     = res_b;
  assign bif_l.clear_all = clr_b;
  flipflop_bank #(
    .CHANNELS(4), .CONFLICT_MODE(3), .EDGE_DETECT(1'b0), .INIT(4'b0000)
  ) dut_l (
    .clk(clk), .rst(rst_b), .bus(bif_l.slave)
  );
  assign mon_out[4] = 64'(bif_l.out);
  assign mon_bar[4] = 64'(bif_l.out_bar);
  assign mon_chg[4] = 64'(bif_l.changed);
  assign mon_cnt[4] = 7'(bif_l.count);

  flipflop_bank_if #(.CHANNELS(64)) bif_w ();
  assign bif_w.set       = set_c;
  assign bif_w.reset     = res_c;
  assign bif_w.clear_all = clr_c;
  flipflop_bank #(
    .CHANNELS(64), .CONFLICT_MODE(1), .EDGE_DETECT(1'b1), .INIT(64'h0)
  ) dut_w (
    .clk(clk), .rst(rst_c), .bus(bif_w.slave)
  );
  assign mon_out[5] = bif_w.out;
  assign mon_bar[5] = bif_w.out_bar;
  assign mon_chg[5] = bif_w.changed;
  assign mon_cnt[5] = bif_w.count;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input int d, input logic [63:0] o, input logic [63:0] c,
                      input logic [6:0] n, input string nm);
    exp_t e;
    e.cyc = cyc + 1;
    e.dut = d;
    e.out = o;
    e.chg = c;
    e.cnt = n;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic push_a(input logic [3:0] o, input logic [3:0] c,
                        input logic [6:0] n, input string nm);
    for (int d = 0; d < 4; d++) push(d, 64'(o), 64'(c), n, nm);
  endtask

  // Monitor: after each rising edge, checks every expectation due by now.
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t        e;
        logic [63:0] eb;
        e  = q.pop_front();
        eb = ~e.out & dmask[e.dut];
        n_cmp++;
        if (e.cyc != cyc || mon_out[e.dut] !== e.out || mon_chg[e.dut] !== e.chg ||
            mon_cnt[e.dut] !== e.cnt || mon_bar[e.dut] !== eb) begin
          n_bad++;
          $display("FAIL %s dut%0d cyc%0d: out=%h chg=%h cnt=%0d bar=%h, want out=%h chg=%h cnt=%0d bar=%h",
                   e.name, e.dut, cyc, mon_out[e.dut], mon_chg[e.dut], mon_cnt[e.dut],
                   mon_bar[e.dut], e.out, e.chg, e.cnt, eb);
        end
      end
    end
  end

  initial begin
    // Group A: reset load with set held
    tick(); rst_a = 1; set_a = 4'b1111; push_a(4'b1010, 4'b0000, 2, "rst_load1");
    tick();                              push_a(4'b1010, 4'b0000, 2, "rst_load2");
    tick(); rst_a = 0;                   push_a(4'b1010, 4'b0000, 2, "no_spur_edge");
    tick(); set_a = 4'b0000;             push_a(4'b1010, 4'b0000, 2, "hold_low");
    tick(); set_a = 4'b0101; res_a = 4'b1010; push_a(4'b0101, 4'b1111, 2, "to_0101");
    tick(); set_a = 4'b0000; res_a = 4'b0000; push_a(4'b0101, 4'b0000, 2, "hold_0101");
    // Conflict modes
    tick(); set_a = 4'b1111; res_a = 4'b1111;
    push(0, 64'h0, 64'h5, 0, "conf_m0");
    push(1, 64'hF, 64'hA, 4, "conf_m1");
    push(2, 64'h5, 64'h0, 2, "conf_m2");
    push(3, 64'hA, 64'hF, 2, "conf_m3");
    tick();
    push(0, 64'h0, 64'h0, 0, "conf_hold_m0");
    push(1, 64'hF, 64'h0, 4, "conf_hold_m1");
    push(2, 64'h5, 64'h0, 2, "conf_hold_m2");
    push(3, 64'hA, 64'h0, 2, "conf_hold_m3");
    tick(); set_a = 4'b0000; res_a = 4'b0000;
    push(0, 64'h0, 64'h0, 0, "idle_m0");
    push(3, 64'hA, 64'h0, 2, "idle_m3");
    // Edge mode: set[0] held three cycles acts once
    for (int k = 0; k < 3; k++) begin
      tick(); set_a = 4'b0001;
      push(0, 64'h1, (k == 0) ? 64'h1 : 64'h0, 1, "edge_set0_m0");
      push(1, 64'hF, 64'h0, 4, "edge_set0_m1");
      push(2, 64'h5, 64'h0, 2, "edge_set0_m2");
      push(3, 64'hB, (k == 0) ? 64'h1 : 64'h0, 3, "edge_set0_m3");
    end
    tick(); set_a = 4'b0000;
    push(0, 64'h1, 64'h0, 1, "rearm_m0");
    tick(); set_a = 4'b1111;
    push(0, 64'hF, 64'hE, 4, "all_set_m0");
    push(1, 64'hF, 64'h0, 4, "all_set_m1");
    push(2, 64'hF, 64'hA, 4, "all_set_m2");
    push(3, 64'hF, 64'h4, 4, "all_set_m3");
    tick(); set_a = 4'b0000;             push_a(4'b1111, 4'b0000, 4, "hold_1111");
    // clear_all beats a coincident set edge, and consumes it
    tick(); clr_a = 1; set_a = 4'b0100;  push_a(4'b0000, 4'b1111, 0, "clear_prio");
    tick(); clr_a = 0;                   push_a(4'b0000, 4'b0000, 0, "clear_edge_lost1");
    tick();                              push_a(4'b0000, 4'b0000, 0, "clear_edge_lost2");
    // Mid-operation reset with strobes present
    tick(); set_a = 4'b0011;             push_a(4'b0011, 4'b0011, 2, "traffic");
    tick(); rst_a = 1; set_a = 4'b1100; res_a = 4'b0011; push_a(4'b1010, 4'b0000, 2, "mid_rst");
    tick(); rst_a = 0;                   push_a(4'b1010, 4'b0000, 2, "post_rst_no_act");
    tick(); set_a = 4'b0000; res_a = 4'b0000; push_a(4'b1010, 4'b0000, 2, "post_rst_idle");

    // Group B: level mode
    tick(); rst_b = 1;                   push(4, 64'h0, 64'h0, 0, "lvl_rst");
    tick(); rst_b = 0; set_b = 4'b0001;  push(4, 64'h1, 64'h1, 1, "lvl_set");
    for (int k = 0; k < 3; k++) begin
      tick(); set_b = 4'b0000; res_b = 4'b0001;
      push(4, 64'h0, (k == 0) ? 64'h1 : 64'h0, 0, "lvl_reset_held");
    end
    tick(); set_b = 4'b1111; res_b = 4'b1111; push(4, 64'hF, 64'hF, 4, "lvl_toggle1");
    tick();                              push(4, 64'h0, 64'hF, 0, "lvl_toggle2");
    tick();                              push(4, 64'hF, 64'hF, 4, "lvl_toggle3");

    // Group C: 64-channel count
    tick(); rst_c = 1;                   push(5, 64'h0, 64'h0, 0, "wide_rst");
    tick(); rst_c = 0; set_c = '1;       push(5, '1, '1, 64, "wide_all_set");
    tick(); set_c = '0;                  push(5, '1, 64'h0, 64, "wide_hold");
    tick(); res_c = 64'h8000_0000_0000_0000;
    push(5, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 63, "wide_clr63");
    tick(); res_c = '0;

    // Drain: every expectation must have been consumed within a few edges
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
